seg_scan_ctrl: RTL and testbench

Parametrised seven-segment scan controller: drives NUM_DIGITS common-anode digits from one of NUM_SRC glyph sources, or blanks the display. It owns digit multiplexing, ghost-suppression dead time, per-source shadow buffering, frame-aligned source switching and optional per-digit blinking. It sits between the calculator status/result logic and the board's `seg`/`an` pins. It replaces the fixed 4-digit, fixed-mode display mux.

---
 rtl/seg_disp_pkg.sv | 18 +
 rtl/seg_glyph_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared glyph definitions for the seven-segment scan controller.
// Segment patterns are active-low, bit order g..a.
package seg_disp_pkg;

    typedef logic [4:0] glyph_t;

    localparam glyph_t GLYPH_BLANK = 5'd16;
    localparam glyph_t GLYPH_MINUS = 5'd17;

    // Codes 0-15 are hex digits, 16 blank, 17 minus, 18-31 blank.
    localparam logic [6:0] SEG_LUT [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h7F, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: 5-bit glyph code to active-low g..a segments.
module seg_glyph_decode
    import seg_disp_pkg::*;
(
    input  glyph_t     code,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[code];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-source shadow buffers and
// frame-aligned source switching. Define SEG_BLINK_EN to enable per-digit blinking.
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int NUM_SRC      = 3,
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(NUM_SRC+1)-1:0]    src_sel,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*NUM_DIGITS*5-1:0] src_code,
    input  logic [NUM_SRC*NUM_DIGITS-1:0]   src_dp,
    input  logic [NUM_DIGITS-1:0]           blink_mask,
    output logic [7:0]                      seg,
    output logic [NUM_DIGITS-1:0]           an,
    output logic                            frame_start
);

    localparam int SEL_W = $clog2(NUM_SRC + 1);
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW    = $clog2(NUM_DIGITS);

    localparam logic [SEL_W-1:0] SEL_OFF  = SEL_W'(NUM_SRC);
    localparam logic [PW-1:0]    PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]    PRE_DEAD = PW'(DEAD_CYCLES);
    localparam logic [DW-1:0]    DIG_LAST = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [DW-1:0]         digit;
    logic [SEL_W-1:0]      pending;
    logic [SEL_W-1:0]      active;
    glyph_t                code_q [NUM_SRC][NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_q   [NUM_SRC];

    logic       slot_end;
    logic       frame_end;
    logic       lit;
    logic       blink_dark;
    glyph_t     cur_code;
    logic       cur_dp;
    logic [6:0] cur_seg;

    assign slot_end  = (presc == PRE_LAST);
    assign frame_end = slot_end && (digit == DIG_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= '0;
            digit   <= '0;
            pending <= SEL_OFF;
            active  <= SEL_OFF;
        end else begin
            pending <= src_sel;
            if (slot_end) begin
                presc <= '0;
                digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            // Source switches only land on the frame boundary so no frame is torn.
            if (frame_end) begin
                active <= pending;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (!rst_n) begin
                dp_q[s] <= '0;
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    code_q[s][d] <= GLYPH_BLANK;
                end
            end else if (src_valid[s]) begin
                dp_q[s] <= src_dp[s*NUM_DIGITS +: NUM_DIGITS];
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    code_q[s][d] <= src_code[(s*NUM_DIGITS+d)*5 +: 5];
                end
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    logic          phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_dark = phase && blink_mask[digit];
`else
    logic blink_unused;
    assign blink_unused = ^blink_mask;
    assign blink_dark   = 1'b0;
`endif

    always_comb begin
        cur_code = GLYPH_BLANK;
        cur_dp   = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (active == SEL_W'(s)) begin
                cur_code = code_q[s][digit];
                cur_dp   = dp_q[s][digit];
            end
        end
    end

    seg_glyph_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    assign lit = (presc >= PRE_DEAD) && (active < SEL_OFF) && !blink_dark;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg         <= 8'hFF;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (presc == '0) && (digit == '0);
            if (lit) begin
                an  <= ~(NUM_DIGITS'(1) << digit);
                seg <= {~cur_dp, cur_seg};
            end else begin
                an  <= '1;
                seg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a cycle-index reference model plus directed checks
// of the scan pattern, source switching, reset and blinking.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int NS = 2;
    localparam int FRAME = 16;

    logic          clk;
    logic          rst_n;
    logic [1:0]    src_sel;
    logic [NS-1:0] src_valid;
    logic [NS*ND*5-1:0] src_code;
    logic [NS*ND-1:0]   src_dp;
    logic [ND-1:0] blink_mask;
    logic [7:0]    seg;
    logic [ND-1:0] an;
    logic          frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: shadow contents and the src_sel seen in each cycle since reset.
    int   m_code [NS][ND];
    bit   m_dp   [NS][ND];
    int   sel_hist[$];

    logic [7:0] cap [ND];
    int         lit_cnt;
    int         fs_cnt;

    // Active-high g..a patterns for hex digits.
    logic [6:0] hex_hi [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .NUM_SRC     (NS),
        .SCAN_DIV    (4),
        .DEAD_CYCLES (1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_sel    (src_sel),
        .src_valid  (src_valid),
        .src_code   (src_code),
        .src_dp     (src_dp),
        .blink_mask (blink_mask),
        .seg        (seg),
        .an         (an),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_low(input int c);
        if (c < 16) return ~hex_hi[c];
        if (c == 17) return ~7'h40;
        return 7'h7F;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        sel_hist.delete();
        for (int s = 0; s < NS; s++)
            for (int d = 0; d < ND; d++) begin
                m_code[s][d] = 16;
                m_dp[s][d]   = 1'b0;
            end
    endtask

    // One clock: predict outputs from the model, advance the model, then compare.
    task automatic tick();
        int k, presc, dig, frame, act, phase;
        bit lit;
        logic [7:0]    e_seg;
        logic [ND-1:0] e_an;
        logic          e_fs;
        e_seg = 8'hFF;
        e_an  = '1;
        e_fs  = 1'b0;
        if (rst_n) begin
            k     = sel_hist.size();
            presc = k % 4;
            dig   = (k / 4) % ND;
            frame = k / FRAME;
            act   = (frame == 0) ? NS : sel_hist[FRAME*frame-2];
            phase = 0;
`ifdef SEG_BLINK_EN
            phase = (frame / 2) % 2;
`endif
            lit  = (presc >= 1) && (act < NS) && !(phase == 1 && blink_mask[dig]);
            e_fs = (k % FRAME == 0);
            if (lit) begin
                e_an[dig] = 1'b0;
                e_seg = {~m_dp[act][dig], glyph_low(m_code[act][dig])};
            end
        end
        if (!rst_n) begin
            reset_model();
        end else begin
            sel_hist.push_back(int'(src_sel));
            for (int s = 0; s < NS; s++)
                if (src_valid[s])
                    for (int d = 0; d < ND; d++) begin
                        m_code[s][d] = int'(src_code[(s*ND+d)*5 +: 5]);
                        m_dp[s][d]   = src_dp[s*ND+d];
                    end
        end
        @(posedge clk);
        #1;
        check("seg", seg, e_seg);
        check("an", {4'b0, an}, {4'b0, e_an});
        check("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
        if (an != '1) lit_cnt++;
        if (frame_start) fs_cnt++;
        for (int d = 0; d < ND; d++)
            if (an == ~(ND'(1) << d)) cap[d] = seg;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_cap();
        for (int d = 0; d < ND; d++) cap[d] = 'x;
        lit_cnt = 0;
        fs_cnt  = 0;
    endtask

    // Run until the model's next state is the first cycle of a frame.
    task automatic to_frame();
        for (int i = 0; i < FRAME && (sel_hist.size() % FRAME) != 0; i++) tick();
    endtask

    task automatic load(input int s, input int c0, input int c1, input int c2,
                        input int c3, input logic [3:0] dp);
        src_code[(s*ND+0)*5 +: 5] = 5'(c0);
        src_code[(s*ND+1)*5 +: 5] = 5'(c1);
        src_code[(s*ND+2)*5 +: 5] = 5'(c2);
        src_code[(s*ND+3)*5 +: 5] = 5'(c3);
        src_dp[s*ND +: ND] = dp;
        src_valid = '0;
        src_valid[s] = 1'b1;
        tick();
        src_valid = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        src_sel    = 2'd0;
        src_valid  = '0;
        src_code   = '0;
        src_dp     = '0;
        blink_mask = '0;
        reset_model();
        clear_cap();
        run(2);
        check("reset_seg", seg, 8'hFF);
        check("reset_an", {4'b0, an}, 8'h0F);
        rst_n = 1'b1;

        // Blank shadows: dark segments, anodes still scan.
        run(2 * FRAME);
        clear_cap();
        run(2 * FRAME);
        check("scan_fs_count", 8'(fs_cnt), 8'd2);
        check("scan_lit_count", 8'(lit_cnt), 8'd24);
        check("scan_blank_d0", cap[0], 8'hFF);

        // Source 0 content.
        load(0, 0, 1, 2, 3, 4'b0010);
        to_frame();
        clear_cap();
        run(FRAME);
        check("src0_d0", cap[0], 8'hC0);
        check("src0_d1", cap[1], 8'h79);
        check("src0_d2", cap[2], 8'hA4);
        check("src0_d3", cap[3], 8'hB0);

        // Switch to source 1 mid-frame; the rest of the frame stays on source 0.
        load(1, 15, 16, 17, 17, 4'b0000);
        for (int i = 0; i < FRAME && ((sel_hist.size() % FRAME) / 4) != 1; i++) tick();
        src_sel = 2'd1;
        clear_cap();
        to_frame();
        check("switch_hold_d3", cap[3], 8'hB0);
        clear_cap();
        run(FRAME);
        check("src1_d0", cap[0], 8'h8E);
        check("src1_d1", cap[1], 8'hFF);
        check("src1_d2", cap[2], 8'hBF);
        check("src1_d3", cap[3], 8'hBF);

        // Display off.
        src_sel = 2'd2;
        run(2 * FRAME);
        clear_cap();
        run(2 * FRAME);
        check("off_lit_count", 8'(lit_cnt), 8'd0);
        check("off_fs_count", 8'(fs_cnt), 8'd2);

        // Reset pulse during digit 2.
        src_sel = 2'd0;
        run(2 * FRAME);
        for (int i = 0; i < FRAME && ((sel_hist.size() % FRAME) / 4) != 2; i++) tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midreset_seg", seg, 8'hFF);
        check("midreset_an", {4'b0, an}, 8'h0F);
        rst_n = 1'b1;
        clear_cap();
        run(FRAME);
        check("postreset_off", 8'(lit_cnt), 8'd0);

        // Blink on digit 0 across several frames.
        load(0, 8, 4, 5, 6, 4'b0001);
        blink_mask = 4'b0001;
        run(6 * FRAME);
        blink_mask = 4'b0000;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) src_sel = 2'($urandom_range(0, 3));
            src_valid = '0;
            if ($urandom_range(0, 9) == 0) begin
                src_valid = NS'($urandom_range(1, 3));
                src_code  = {$urandom(), $urandom()};
                src_dp    = 8'($urandom());
            end
            if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom());
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_n     = 1'b1;
        src_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
